// File: rtl/decode_check_pipeline_pkg.sv
// Shared widths, S1 beat record and the opcode-to-one-hot decode for the
// decode/check pipeline.
package decode_check_pipeline_pkg;

    localparam int unsigned OPCODE_W  = 3;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned FUNC_W    = 8;
    localparam int unsigned ERR_CNT_W = 4;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 4'hF;

    typedef struct packed {
        logic                valid;
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   x;
        logic                parity;
    } s1_beat_t;

    // Opcode 0 selects the MSB so this inverts the team's one-hot encoder.
    function automatic logic [FUNC_W-1:0] decode_func(input logic [OPCODE_W-1:0] op);
        logic [FUNC_W-1:0] msb_one;
        msb_one = {1'b1, {(FUNC_W-1){1'b0}}};
        return msb_one >> op;
    endfunction

endpackage

// File: rtl/decode_check_pipeline_parity_checker.sv
// Even-parity check of a data word: error is high when the total XOR is 1.
module parity_checker
    import decode_check_pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              parity,
    output logic              error
);

    assign error = ^{data, parity};

endmodule

// File: rtl/decode_check_pipeline.sv
// Two-stage pipeline: S1 captures the input beat, S2 registers the one-hot
// decode, the parity check and a saturating sticky error counter.
module decode_check_pipeline
    import decode_check_pipeline_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [DATA_W-1:0]    X,
    input  logic                 parity,
    input  logic                 clr_err,
    output logic                 out_valid,
    output logic [FUNC_W-1:0]    func,
    output logic [DATA_W-1:0]    data_out,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_sticky
);

    s1_beat_t s1_q;

    logic                 out_valid_q, out_valid_d;
    logic [FUNC_W-1:0]    func_q, func_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 perr_q, perr_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    logic chk_err;
    logic load_err;

    parity_checker u_parity_checker (
        .data   (s1_q.x),
        .parity (s1_q.parity),
        .error  (chk_err)
    );

    assign load_err = s1_q.valid & chk_err;

    always_comb begin
        out_valid_d = 1'b0;
        func_d      = '0;
        data_d      = data_q;
        perr_d      = 1'b0;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;

        if (s1_q.valid) begin
            out_valid_d = 1'b1;
            func_d      = decode_func(s1_q.opcode);
            data_d      = s1_q.x;
            perr_d      = chk_err;
        end

        // A clear coinciding with a new error still counts that error.
        if (load_err) begin
            sticky_d = 1'b1;
            if (clr_err) begin
                cnt_d = ERR_CNT_W'(1);
            end else if (cnt_q != ERR_CNT_MAX) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
        end else if (clr_err) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            func_q      <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_q.valid  <= in_valid;
            s1_q.opcode <= opcode;
            s1_q.x      <= X;
            s1_q.parity <= parity;
            out_valid_q <= out_valid_d;
            func_q      <= func_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign func       = func_q;
    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign err_count  = cnt_q;
    assign err_sticky = sticky_q;

endmodule

// File: doc/decode_check_pipeline.md
DECODE_CHECK_PIPELINE -- requirements
Module: decode_check_pipeline

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset.
REQ-002 Port clk, input, 1 bit: clock.
REQ-003 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: opcode/X/parity carry a beat this cycle.
REQ-005 Port opcode, input, 3 bits: encoded function code.
REQ-006 Port X, input, 4 bits: data word from the ALU result path.
REQ-007 Port parity, input, 1 bit: even-parity bit for X.
REQ-008 Port clr_err, input, 1 bit: synchronous clear of the error counter and sticky flag.
REQ-009 Port out_valid, output, 1 bit: the output beat is valid.
REQ-010 Port func, output, 8 bits: one-hot decoded function code.
REQ-011 Port data_out, output, 4 bits: X delayed through the pipeline.
REQ-012 Port parity_err, output, 1 bit: the current output beat failed the parity check.
REQ-013 Port err_count, output, 4 bits: saturating count of parity errors.
REQ-014 Port err_sticky, output, 1 bit: at least one error has occurred since the last reset or clear.

Function
REQ-015 The block SHALL have two register stages: S1 captures in_valid, opcode, X and parity; S2 registers the decode and check results onto the outputs.
REQ-016 Latency SHALL be two edges: a beat presented before edge k is captured at edge k and appears on the outputs after edge k+1.
REQ-017 Throughput SHALL be one beat per cycle, with no stalls and no backpressure.
REQ-018 Decode SHALL be func = 8'b1000_0000 >> opcode (opcode 0 gives func[7], opcode 7 gives func[0]), exactly the inverse of the team's one-hot encoder.
REQ-019 The check SHALL be parity_err = ^{X, parity}, so a total XOR of 1 is an error under even parity.
REQ-020 When S1 holds a valid beat, S2 SHALL load out_valid=1, func=decoded value, data_out=X and parity_err=check result.
REQ-021 When S1 holds no valid beat, S2 SHALL load out_valid=0, func=8'h00 and parity_err=0, and data_out SHALL hold its previous value.
REQ-022 err_count SHALL increment at the edge that loads a valid beat with parity_err=1.
REQ-023 err_count SHALL saturate at 15 (4'hF) and never wrap to 0.
REQ-024 err_sticky SHALL set at the same edge as each increment and stay set until reset or clr_err.
REQ-025 If clr_err is asserted at the edge where no error is loaded, err_count SHALL become 0 and err_sticky 0.
REQ-026 If clr_err coincides with an error being loaded, err_count SHALL become 1 and err_sticky 1 (the new error is counted).
REQ-027 Data SHALL pass through unmodified on a parity error; the block flags errors and never corrects or drops a beat.
REQ-028 in_valid=0 SHALL leave err_count and err_sticky unchanged, whatever values opcode, X and parity hold.

Reset
REQ-029 Reset SHALL take effect asynchronously, without waiting for clk.
REQ-030 During reset, all S1 registers SHALL clear to 0.
REQ-031 During reset, the outputs SHALL be out_valid=0, func=8'h00, data_out=4'h0, parity_err=0, err_count=4'h0 and err_sticky=0.
REQ-032 Asserting reset mid-stream SHALL discard every in-flight beat, and no beat captured before reset SHALL appear after it.
REQ-033 The first beat SHALL be captured at the first rising edge after reset is released.

Structure
REQ-034 A shared package SHALL hold OPCODE_W=3, DATA_W=4, FUNC_W=8, ERR_CNT_W=4 and ERR_CNT_MAX=15.
REQ-035 A single combinational sub-module, parity_checker (input 4-bit data and 1-bit parity, output 1-bit error), SHALL implement the check.
REQ-036 The decode, the pipeline registers and the error counter SHALL live in decode_check_pipeline itself.

Verification
REQ-037 Basic decode: with in_valid=1, opcode=3'b001, X=4'b1011 and parity=1 before edge k, the outputs after edge k+1 SHALL be out_valid=1, func=8'b0100_0000, data_out=4'b1011 and parity_err=0.
REQ-038 Error counting: with opcode=3'b111, X=4'b0011 and parity=1, the outputs SHALL be func=8'b0000_0001, parity_err=1, err_count=1 and err_sticky=1.
REQ-039 Saturation: 17 consecutive error beats SHALL leave err_count=4'hF after the 15th beat and through the 17th; a later clr_err with no error SHALL give err_count=0 and err_sticky=0.
REQ-040 Simultaneous clear: clr_err=1 at the edge loading an error beat while err_count=5 SHALL give err_count=1 and err_sticky=1.
REQ-041 Bubbles: the sequence valid, invalid, valid SHALL give out_valid=1,0,1 at the 2-edge offset, with func=8'h00 and data_out held during the bubble.
REQ-042 Reset mid-stream: asserting reset between edges while two beats are in flight SHALL zero all outputs immediately, and out_valid SHALL stay 0 until two edges after the first post-reset beat.
